copi_frame_scheduler: RTL

COPI_FRAME_SCHEDULER -- requirements
Module: copi_frame_scheduler

---
 rtl/copi_frame_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/copi_frame_scheduler.sv
// COPI slot scheduler: CONVERT then 3 AUX slots per frame; responses land 1 cycle after slot_req, no backpressure.
// Command queue drops pushes when full unless popped the same cycle; SCHED_STATS_EN enables issued/drop counters.
module copi_frame_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CONV   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          frame_start,
    input  logic                          slot_req,
    output logic [15:0]                   slot_word,
    output logic                          slot_valid,
    output logic                          slot_is_queued,
    output logic [1:0]                    slot_tag,
    input  logic                          cmd_wr_en,
    input  logic [15:0]                   cmd_wr_data,
    output logic                          cmd_full,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
    input  logic [15:0]                   aux_default,
    output logic                          seq_error,
    output logic [31:0]                   issued_count,
    output logic [31:0]                   drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] AUX     = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]    r_state;
    logic [SW-1:0] r_slot;
    logic          r_valid, r_queued, r_seq_err;
    logic [15:0]   r_word;
    logic [1:0]    r_tag;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;

    logic [1:0]    w_st, w_nxt_st;
    logic [SW-1:0] w_slot, w_nxt_slot;
    logic          w_fs_err, w_req_err, w_pop, w_push, w_full, w_empty, w_queued;
    logic [15:0]   w_word;
    logic [1:0]    w_tag;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = cmd_wr_en && (!w_full || w_pop);

    // frame_start is resolved first so a coincident slot_req is served against the restarted frame
    always_comb begin
        w_st     = r_state;
        w_slot   = r_slot;
        w_fs_err = 1'b0;
        if (frame_start) begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        w_st   = CONVERT;
                        w_slot = '0;
                    end
                end
                CONVERT, AUX: begin
                    w_st     = CONVERT;
                    w_slot   = '0;
                    w_fs_err = 1'b1;
                end
                default: begin
                    w_st   = enable ? CONVERT : IDLE;
                    w_slot = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_nxt_st   = w_st;
        w_nxt_slot = w_slot;
        w_word     = aux_default;
        w_tag      = 2'd3;
        w_queued   = 1'b0;
        w_pop      = 1'b0;
        w_req_err  = 1'b0;
        if (slot_req) begin
            case (w_st)
                CONVERT: begin
                    w_word = {2'b00, w_slot[5:0], 8'h00};
                    if (w_slot == SW'(NUM_CONV - 1)) begin
                        w_nxt_st   = AUX;
                        w_nxt_slot = '0;
                    end else begin
                        w_nxt_slot = w_slot + SW'(1);
                    end
                end
                AUX: begin
                    w_tag = w_slot[1:0];
                    if (!w_empty) begin
                        w_pop    = 1'b1;
                        w_queued = 1'b1;
                        w_word   = r_mem[r_rd_ptr];
                    end
                    if (w_slot == SW'(2)) begin
                        w_nxt_st   = DONE;
                        w_nxt_slot = '0;
                    end else begin
                        w_nxt_slot = w_slot + SW'(1);
                    end
                end
                default: w_req_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_slot    <= '0;
            r_valid   <= 1'b0;
            r_word    <= '0;
            r_queued  <= 1'b0;
            r_tag     <= 2'd3;
            r_seq_err <= 1'b0;
        end else begin
            r_state <= w_nxt_st;
            r_slot  <= w_nxt_slot;
            r_valid <= slot_req;
            if (slot_req) begin
                r_word   <= w_word;
                r_tag    <= w_tag;
                r_queued <= w_queued;
            end
            if (w_fs_err || w_req_err) r_seq_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    // storage needs no reset: pointers and count define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= cmd_wr_data;
    end

`ifdef SCHED_STATS_EN
    logic [31:0] r_issued, r_drop;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued <= '0;
            r_drop   <= '0;
        end else begin
            if (w_pop)               r_issued <= r_issued + 32'd1;
            if (cmd_wr_en && !w_push) r_drop   <= r_drop + 32'd1;
        end
    end
    assign issued_count = r_issued;
    assign drop_count   = r_drop;
`else
    assign issued_count = 32'd0;
    assign drop_count   = 32'd0;
`endif

    assign slot_word      = r_word;
    assign slot_valid     = r_valid;
    assign slot_is_queued = r_queued;
    assign slot_tag       = r_tag;
    assign seq_error      = r_seq_err;
    assign cmd_full       = w_full;
    assign cmd_count      = r_count;
endmodule
